// File: rtl/uart_frame_loader_if.sv
// Bundles the serial input and the frame-loader outputs into one port.
//   master : the loader side (receives uart_rx, drives frame and debug outputs)
//   slave  : the consumer / line-driver side
// Signals:
//   uart_rx        serial input, idle high, 8N1, LSB first
//   u_out          last complete frame, element k at [k*WIDTH +: WIDTH]
//   load_valid     one-cycle pulse when u_out has just been updated
//   rx_byte        last good byte received
//   rx_byte_valid  one-cycle pulse per good byte
//   frame_err      one-cycle pulse on a bad stop bit
//   busy           high from the first header byte until load_valid
interface uart_frame_loader_if #(
   parameter int N_CELLS = 20,
   parameter int WIDTH   = 32
);
   logic                       uart_rx;
   logic [N_CELLS*WIDTH-1:0]   u_out;
   logic                       load_valid;
   logic [7:0]                 rx_byte;
   logic                       rx_byte_valid;
   logic                       frame_err;
   logic                       busy;

   modport master (
      input  uart_rx,
      output u_out, load_valid, rx_byte, rx_byte_valid, frame_err, busy
   );

   modport slave (
      output uart_rx,
      input  u_out, load_valid, rx_byte, rx_byte_valid, frame_err, busy
   );
endinterface

// File: rtl/uart_frame_loader.sv
// UART receiver plus frame parser that loads the wave solver's initial
// displacement array. It hunts for HEADER_LEN copies of HEADER_BYTE, then
// collects N_CELLS little-endian WIDTH-bit elements into a shadow buffer and
// copies the whole buffer to u_out with a one-cycle load_valid strobe.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    uart_frame_loader_if.master (uart_rx in; u_out, load_valid,
//          rx_byte, rx_byte_valid, frame_err, busy out)
module uart_frame_loader #(
   parameter int         CLKS_PER_BIT = 235,
   parameter int         N_CELLS      = 20,
   parameter int         WIDTH        = 32,
   parameter logic [7:0] HEADER_BYTE  = 8'h01,
   parameter int         HEADER_LEN   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_frame_loader_if.master bus
);
   localparam int FRAME_W = N_CELLS * WIDTH;
   localparam int N_BYTES = FRAME_W / 8;

   localparam logic [11:0] HALF_M1  = 12'(CLKS_PER_BIT / 2 - 1);
   localparam logic [11:0] FULL_M1  = 12'(CLKS_PER_BIT - 1);
   localparam logic [9:0]  LAST_IDX = 10'(N_BYTES - 1);
   localparam logic [7:0]  HDR_LAST = 8'(HEADER_LEN - 1);

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_WAIT  = 3'd4;   // after a bad stop bit: wait for line high

   localparam logic [1:0] P_HUNT   = 2'd0;
   localparam logic [1:0] P_LOAD   = 2'd1;
   localparam logic [1:0] P_COMMIT = 2'd2;

   logic               rx_meta_q, rx_s_q;
   logic [2:0]         rx_state_q, rx_state_d;
   logic [11:0]        clk_cnt_q, clk_cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic [7:0]         rx_byte_q, rx_byte_d;
   logic               rx_byte_valid_q, rx_byte_valid_d;
   logic               frame_err_q, frame_err_d;
   logic [1:0]         p_state_q, p_state_d;
   logic [7:0]         hdr_cnt_q, hdr_cnt_d;
   logic [9:0]         byte_idx_q, byte_idx_d;
   logic [FRAME_W-1:0] shadow_q, shadow_d;
   logic [FRAME_W-1:0] u_out_q, u_out_d;
   logic               load_valid_q, load_valid_d;
   logic               busy_q, busy_d;

   // Bit-level receiver: start bit checked at mid-bit, data and stop bits
   // sampled one bit period apart from there, LSB shifted in first.
   always_comb begin
      rx_state_d      = rx_state_q;
      clk_cnt_d       = clk_cnt_q + 12'd1;
      bit_idx_d       = bit_idx_q;
      shift_d         = shift_q;
      rx_byte_d       = rx_byte_q;
      rx_byte_valid_d = 1'b0;
      frame_err_d     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (clk_cnt_q == HALF_M1) begin
               clk_cnt_d  = '0;
               bit_idx_d  = '0;
               // A line that is high again at mid-start was a glitch.
               rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (clk_cnt_q == FULL_M1) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  rx_byte_d       = shift_q;
                  rx_byte_valid_d = 1'b1;
                  rx_state_d      = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  rx_state_d  = RX_WAIT;
               end
            end
         end
         RX_WAIT: begin
            clk_cnt_d = '0;
            if (rx_s_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // Frame parser: header hunt, byte collection into the shadow buffer,
   // then a single commit cycle that publishes the whole frame at once.
   always_comb begin
      p_state_d    = p_state_q;
      hdr_cnt_d    = hdr_cnt_q;
      byte_idx_d   = byte_idx_q;
      shadow_d     = shadow_q;
      u_out_d      = u_out_q;
      load_valid_d = 1'b0;
      busy_d       = busy_q;
      if (frame_err_q) begin
         // A framing error means byte alignment is lost: drop the frame.
         p_state_d = P_HUNT;
         hdr_cnt_d = '0;
         busy_d    = 1'b0;
      end else begin
         case (p_state_q)
            P_HUNT: begin
               if (rx_byte_valid_q) begin
                  if (rx_byte_q == HEADER_BYTE) begin
                     busy_d    = 1'b1;
                     hdr_cnt_d = hdr_cnt_q + 8'd1;
                     if (hdr_cnt_q == HDR_LAST) begin
                        byte_idx_d = '0;
                        p_state_d  = P_LOAD;
                     end
                  end else begin
                     hdr_cnt_d = '0;
                     busy_d    = 1'b0;
                  end
               end
            end
            P_LOAD: begin
               if (rx_byte_valid_q) begin
                  for (int i = 0; i < N_BYTES; i++) begin
                     if (byte_idx_q == 10'(i)) shadow_d[i*8 +: 8] = rx_byte_q;
                  end
                  byte_idx_d = byte_idx_q + 10'd1;
                  if (byte_idx_q == LAST_IDX) p_state_d = P_COMMIT;
               end
            end
            P_COMMIT: begin
               u_out_d      = shadow_q;
               load_valid_d = 1'b1;
               busy_d       = 1'b0;
               hdr_cnt_d    = '0;
               p_state_d    = P_HUNT;
            end
            default: p_state_d = P_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q       <= 1'b1;
         rx_s_q          <= 1'b1;
         rx_state_q      <= RX_IDLE;
         clk_cnt_q       <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         rx_byte_q       <= '0;
         rx_byte_valid_q <= 1'b0;
         frame_err_q     <= 1'b0;
         p_state_q       <= P_HUNT;
         hdr_cnt_q       <= '0;
         byte_idx_q      <= '0;
         shadow_q        <= '0;
         u_out_q         <= '0;
         load_valid_q    <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         rx_meta_q       <= bus.uart_rx;
         rx_s_q          <= rx_meta_q;
         rx_state_q      <= rx_state_d;
         clk_cnt_q       <= clk_cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         rx_byte_q       <= rx_byte_d;
         rx_byte_valid_q <= rx_byte_valid_d;
         frame_err_q     <= frame_err_d;
         p_state_q       <= p_state_d;
         hdr_cnt_q       <= hdr_cnt_d;
         byte_idx_q      <= byte_idx_d;
         shadow_q        <= shadow_d;
         u_out_q         <= u_out_d;
         load_valid_q    <= load_valid_d;
         busy_q          <= busy_d;
      end
   end

   assign bus.u_out         = u_out_q;
   assign bus.load_valid    = load_valid_q;
   assign bus.rx_byte       = rx_byte_q;
   assign bus.rx_byte_valid = rx_byte_valid_q;
   assign bus.frame_err     = frame_err_q;
   assign bus.busy          = busy_q;
endmodule
